// File: rtl/sort_ctrl.sv
// In-place bubble sort of a small unsigned buffer, with early exit.
// A single time-shared magnitude comparator examines one neighbour pair per cycle.

module sort_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

module sort_ctrl #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clr,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 swap_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, CMP, SWAP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  mem_reg  [DEPTH];
  logic [WIDTH-1:0]  mem_next [DEPTH];
  logic [CW-1:0]     count_reg, count_next;
  logic [AW-1:0]     j_reg, j_next, j_inc;
  logic [AW-1:0]     pass_reg, pass_next;
  logic              swapped_reg, swapped_next;
  logic [7:0]        swap_cnt_reg, swap_cnt_next;
  logic              do_load, do_swap, advance, swapped_eff;
  logic [CW-1:0]     pass_limit;
  logic              pass_end, pass_last;
  logic              cmp_lt, cmp_eq, cmp_gt;

  assign j_inc = j_reg + AW'(1);

  sort_cmp #(.W(WIDTH)) u_cmp (
    .a  (mem_reg[j_reg]),
    .b  (mem_reg[j_inc]),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // Last compare index of the current pass is count-2-pass.
  assign pass_limit  = count_reg - CW'(2) - CW'(pass_reg);
  assign pass_end    = !(CW'(j_reg) < pass_limit);
  assign pass_last   = (CW'(pass_reg) == count_reg - CW'(2));
  assign swapped_eff = swapped_reg | do_swap;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    j_next        = j_reg;
    pass_next     = pass_reg;
    swapped_next  = swapped_reg;
    swap_cnt_next = swap_cnt_reg;
    do_load       = 1'b0;
    do_swap       = 1'b0;
    advance       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && count_reg >= CW'(2)) begin
          state_next    = CMP;
          j_next        = '0;
          pass_next     = '0;
          swapped_next  = 1'b0;
          swap_cnt_next = '0;
        end else if (start && count_reg == CW'(1)) begin
          state_next    = DONE;
          swap_cnt_next = '0;
        end else if (clr) begin
          count_next = '0;
        end else if (load && count_reg != CW'(DEPTH)) begin
          do_load    = 1'b1;
          count_next = count_reg + CW'(1);
        end
      end
      CMP: begin
        if (cmp_gt) state_next = SWAP;
        else        advance    = 1'b1;
      end
      SWAP: begin
        do_swap      = 1'b1;
        swapped_next = 1'b1;
        if (swap_cnt_reg != 8'hFF) swap_cnt_next = swap_cnt_reg + 8'd1;
        advance      = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (!pass_end) begin
        j_next     = j_inc;
        state_next = CMP;
      end else if (!swapped_eff || pass_last) begin
        state_next = DONE;
      end else begin
        // Next pass starts straight away, no idle cycle in between.
        pass_next    = pass_reg + AW'(1);
        j_next       = '0;
        swapped_next = 1'b0;
        state_next   = CMP;
      end
    end
  end

  // Per-entry next value: load into the first free slot, or exchange with a neighbour.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] hi_val, lo_val;
      if (gi < DEPTH-1) begin : g_hi
        assign hi_val = mem_reg[gi+1];
      end else begin : g_hi_none
        assign hi_val = mem_reg[gi];
      end
      if (gi > 0) begin : g_lo
        assign lo_val = mem_reg[gi-1];
      end else begin : g_lo_none
        assign lo_val = mem_reg[gi];
      end
      assign mem_next[gi] =
        (do_load && count_reg == CW'(gi)) ? din    :
        (do_swap && j_reg == AW'(gi))     ? hi_val :
        (do_swap && j_inc == AW'(gi))     ? lo_val :
                                            mem_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      j_reg        <= '0;
      pass_reg     <= '0;
      swapped_reg  <= 1'b0;
      swap_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      j_reg        <= j_next;
      pass_reg     <= pass_next;
      swapped_reg  <= swapped_next;
      swap_cnt_reg <= swap_cnt_next;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
    end
  end

  assign dout     = mem_reg[rd_addr];
  assign count    = count_reg;
  assign busy     = (state_reg == CMP) || (state_reg == SWAP);
  assign done     = (state_reg == DONE);
  assign swap_cnt = swap_cnt_reg;

  // Only "greater" steers the sort; the other two outputs are observed here.
  a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot({cmp_lt, cmp_eq, cmp_gt}));

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: directed vector table, hand-written corner
// sequences and random buffers checked against an inversion-count reference.
`timescale 1ns/1ps
module tb_sort_ctrl;
  localparam int WIDTH = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, clr = 1'b0, start = 1'b0;
  logic [4:0] din = '0;
  logic [1:0] rd_addr = '0;
  logic [4:0] dout;
  logic [2:0] count;
  logic       busy, done;
  logic [7:0] swap_cnt;

  sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din), .clr(clr),
    .start(start), .rd_addr(rd_addr), .dout(dout), .count(count),
    .busy(busy), .done(done), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][4:0] v;
    logic [3:0][4:0] s;
    logic [7:0]      swaps;
    logic [7:0]      lat;
  } vec_t;

  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_in [4];
  int   m_out [4];
  int   m_swaps, m_lat;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input int v);
    load = 1'b1;
    din  = 5'(v);
    step();
    load = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic read_chk(input string name, input int idx, input int exp);
    rd_addr = 2'(idx);
    #1;
    chk(name, int'(dout), exp);
  endtask

  // mode 0: plain start; 1: start with load in same cycle; 2: inputs toggled while busy
  task automatic run_sort(input string name, input int n, input int exp_lat,
                          input int exp_swaps, input int mode);
    int lat;
    int busy_n;
    start = 1'b1;
    if (mode == 1) begin
      load = 1'b1;
      din  = 5'd9;
    end
    step();
    start = 1'b0;
    load  = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (mode == 2) begin
        load  = 1'($urandom_range(0, 1));
        din   = 5'($urandom_range(0, 31));
        clr   = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    load = 1'b0;
    clr = 1'b0;
    start = 1'b0;
    chk({name, " done_seen"}, int'(done), 1);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " busy_cycles"}, busy_n, exp_lat);
    chk({name, " swap_cnt"}, int'(swap_cnt), exp_swaps);
    $display("sort %s: n=%0d latency=%0d busy=%0d swaps=%0d", name, n, lat, busy_n, swap_cnt);
    step();
    chk({name, " done_width"}, int'(done), 0);
    chk({name, " busy_after"}, int'(busy), 0);
    chk({name, " count_kept"}, int'(count), n);
  endtask

  // Reference: bubble swaps = inversions; swapping passes = max count of larger
  // elements to the left of any element, plus one clean pass unless capped at n-1.
  task automatic model(input int n);
    int maxleft, inv, left, passes, cmps, t;
    maxleft = 0;
    inv = 0;
    cmps = 0;
    for (int i = 0; i < n; i++) begin
      left = 0;
      for (int k = 0; k < i; k++) if (m_in[k] > m_in[i]) left++;
      inv += left;
      if (left > maxleft) maxleft = left;
      m_out[i] = m_in[i];
    end
    for (int i = 1; i < n; i++)
      for (int k = i; k > 0 && m_out[k-1] > m_out[k]; k--) begin
        t = m_out[k]; m_out[k] = m_out[k-1]; m_out[k-1] = t;
      end
    passes = (n < 2) ? 0 : ((maxleft + 1 < n - 1) ? maxleft + 1 : n - 1);
    for (int p = 0; p < passes; p++) cmps += n - 1 - p;
    m_swaps = inv;
    m_lat = cmps + inv;
  endtask

  task automatic set_vec(input int k, input int n, input int a0, input int a1, input int a2,
                         input int a3, input int s0, input int s1, input int s2, input int s3,
                         input int sw, input int lat);
    vecs[k].n = 3'(n);
    vecs[k].v[0] = 5'(a0); vecs[k].v[1] = 5'(a1); vecs[k].v[2] = 5'(a2); vecs[k].v[3] = 5'(a3);
    vecs[k].s[0] = 5'(s0); vecs[k].s[1] = 5'(s1); vecs[k].s[2] = 5'(s2); vecs[k].s[3] = 5'(s3);
    vecs[k].swaps = 8'(sw);
    vecs[k].lat = 8'(lat);
  endtask

  initial begin
    int busy_seen, done_seen, n;

    set_vec(0, 4,  3,  1,  2, 0,  0,  1,  2,  3, 5, 11);
    set_vec(1, 4, 31, 20, 10, 0,  0, 10, 20, 31, 6, 12);
    set_vec(2, 4,  0,  1,  2, 3,  0,  1,  2,  3, 0,  3);
    set_vec(3, 2,  5,  5,  0, 0,  5,  5,  0,  0, 0,  1);
    set_vec(4, 1,  7,  0,  0, 0,  7,  0,  0,  0, 0,  0);
    set_vec(5, 3,  2,  9,  1, 0,  1,  2,  9,  0, 2,  5);

    // Reset state
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst count", int'(count), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst swap_cnt", int'(swap_cnt), 0);
    for (int i = 0; i < 4; i++) read_chk("rst dout", i, 0);

    // Load and overflow
    load_val(3); load_val(1); load_val(2); load_val(0);
    chk("load count", int'(count), 4);
    read_chk("load rd0", 0, 3); read_chk("load rd1", 1, 1);
    read_chk("load rd2", 2, 2); read_chk("load rd3", 3, 0);
    chk("load busy", int'(busy), 0);
    chk("load done", int'(done), 0);
    load_val(17);
    chk("overflow count", int'(count), 4);
    read_chk("overflow rd3", 3, 0);

    // Directed vector table
    for (int k = 0; k < 6; k++) begin
      do_clr();
      for (int i = 0; i < int'(vecs[k].n); i++) load_val(int'(vecs[k].v[i]));
      run_sort($sformatf("vec%0d", k), int'(vecs[k].n), int'(vecs[k].lat),
               int'(vecs[k].swaps), 0);
      for (int i = 0; i < int'(vecs[k].n); i++)
        read_chk($sformatf("vec%0d rd%0d", k, i), i, int'(vecs[k].s[i]));
    end

    // start with an empty buffer does nothing
    do_clr();
    start = 1'b1;
    step();
    start = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy) busy_seen++;
      if (done) done_seen++;
      step();
    end
    chk("empty start busy", busy_seen, 0);
    chk("empty start done", done_seen, 0);
    chk("empty start count", int'(count), 0);

    // start beats load in the same cycle
    load_val(4); load_val(3);
    run_sort("start_load", 2, 2, 1, 1);
    read_chk("start_load rd0", 0, 3);
    read_chk("start_load rd1", 1, 4);

    // Inputs toggled during the sort are ignored
    do_clr();
    load_val(3); load_val(1); load_val(2); load_val(0);
    run_sort("lockout", 4, 11, 5, 2);
    for (int i = 0; i < 4; i++) read_chk($sformatf("lockout rd%0d", i), i, i);

    // Reset in the middle of a sort
    do_clr();
    load_val(31); load_val(20); load_val(10); load_val(0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst count", int'(count), 0);
    chk("midrst swap_cnt", int'(swap_cnt), 0);
    for (int i = 0; i < 4; i++) read_chk("midrst dout", i, 0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (done) done_seen++;
    end
    chk("midrst no_done", done_seen, 0);
    load_val(2); load_val(1);
    run_sort("after_rst", 2, 2, 1, 0);
    read_chk("after_rst rd0", 0, 1);
    read_chk("after_rst rd1", 1, 2);

    // Random buffers against the reference
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        m_in[i] = (it % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      model(n);
      do_clr();
      for (int i = 0; i < n; i++) load_val(m_in[i]);
      run_sort($sformatf("rand%0d", it), n, m_lat, m_swaps, 0);
      for (int i = 0; i < n; i++)
        read_chk($sformatf("rand%0d rd%0d", it, i), i, m_out[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
